piso_tx: RTL and testbench



---
 rtl/piso_tx_pkg.sv | 13 +
 rtl/piso_tx_shreg.sv | 38 +++
 rtl/piso_tx.sv | 113 +++++++++++
 tb/tb_piso_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared constants for the lock-datapath serial transmitter.
// Holds the FSM state encodings and the serial line levels.
package piso_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/piso_tx_shreg.sv
// WIDTH-bit load/shift register for piso_tx; presents the next bit to send
// at the end selected by msb_first and shifts toward it with zero fill.
module piso_shreg
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic             msb_first,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = data_i;
        end else if (shift) begin
            shreg_d = msb_first ? (shreg_q << 1) : (shreg_q >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign bit_o = msb_first ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/piso_tx.sv
// Framed parallel-in serial-out transmitter: start(0), WIDTH data bits, stop(1),
// advanced one bit per ce strobe. Line, done and state are all registered.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ce,
    input  logic [WIDTH-1:0] data_i,
    input  logic             load_i,
    output logic             ready_o,
    output logic             ser_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          DIR_MSB  = (MSB_FIRST != 0);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ser_q, ser_d;
    logic          done_q, done_d;
    logic          sh_load, sh_shift, sh_bit;

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk       (clk),
        .clr       (clr),
        .load      (sh_load),
        .shift     (sh_shift),
        .msb_first (DIR_MSB),
        .data_i    (data_i),
        .bit_o     (sh_bit)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ser_d    = ser_q;
        done_d   = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // ce is deliberately ignored here: a load always wins.
                ser_d = IDLE_LEVEL;
                if (load_i) begin
                    sh_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_START;
                    ser_d   = START_LEVEL;
                end
            end
            ST_START: begin
                ser_d = START_LEVEL;
                if (ce) begin
                    state_d  = ST_DATA;
                    ser_d    = sh_bit;
                    sh_shift = 1'b1;
                    cnt_d    = CNT_ONE;
                end
            end
            ST_DATA: begin
                if (ce) begin
                    if (cnt_q < CNT_LAST) begin
                        ser_d    = sh_bit;
                        sh_shift = 1'b1;
                        cnt_d    = cnt_q + CNT_ONE;
                    end else begin
                        state_d = ST_STOP;
                        ser_d   = IDLE_LEVEL;
                    end
                end
            end
            ST_STOP: begin
                ser_d = IDLE_LEVEL;
                if (ce) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ser_d   = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ser_q   <= IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign busy_o  = ~ready_o;
    assign ser_o   = ser_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: an MSB-first and an LSB-first instance share
// stimulus; a monitor rebuilds each frame from the line and checks it at done_o.
module tb_piso_tx;

    typedef struct {
        logic [5:0] bits;   // line bits in send order, first bit at [5]
        int         clks;   // clocks from load edge to done edge, 0 = unchecked
    } exp_t;

    logic       clk = 1'b0;
    logic       clr, ce, load_i;
    logic [3:0] data_i;
    logic       ser[2], rdy[2], bsy[2], dn[2];

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int phase  = 0;
    bit ce_en  = 1'b1;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .clr(clr), .ce(ce), .data_i(data_i), .load_i(load_i),
        .ready_o(rdy[0]), .ser_o(ser[0]), .busy_o(bsy[0]), .done_o(dn[0])
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .clr(clr), .ce(ce), .data_i(data_i), .load_i(load_i),
        .ready_o(rdy[1]), .ser_o(ser[1]), .busy_o(bsy[1]), .done_o(dn[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_out(input string tag, input logic s, input logic r, input logic b, input logic d);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_ser%0d", tag, k), 32'(ser[k]), 32'(s));
            chk($sformatf("%s_rdy%0d", tag, k), 32'(rdy[k]), 32'(r));
            chk($sformatf("%s_bsy%0d", tag, k), 32'(bsy[k]), 32'(b));
            chk($sformatf("%s_done%0d", tag, k), 32'(dn[k]), 32'(d));
        end
    endtask

    task automatic push_exp(input logic [5:0] msb_bits, input logic [5:0] lsb_bits, input int clks);
        exp_t e;
        e.clks = clks;
        e.bits = msb_bits;
        q0.push_back(e);
        e.bits = lsb_bits;
        q1.push_back(e);
    endtask

    // ce strobes every 4th clock while enabled; inputs change on negedges.
    task automatic step();
        @(negedge clk);
        ce    = ce_en && (phase == 0);
        phase = (phase + 1) % 4;
    endtask

    // Load coincides with a ce edge, so each bit (start included) lasts 4 clks.
    task automatic send(input logic [3:0] d);
        do step(); while (ce !== 1'b1);
        load_i = 1'b1;
        data_i = d;
        step();
        load_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (dn[0] !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout actual=no_done required=done", tag);
        end
        step();
    endtask

    // Monitor: rebuild frames from the line, compare at each done pulse.
    logic [5:0] cap[2];
    int         nbits[2], cyc[2];
    bit         in_frame[2], busy_prev[2], done_prev[2], rdy_hi[2];

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (clr === 1'b1) begin
                in_frame[k]  = 1'b0;
                busy_prev[k] = 1'b0;
                done_prev[k] = 1'b0;
            end else begin
                if (in_frame[k]) begin
                    cyc[k]++;
                    if (ce && bsy[k]) begin
                        cap[k] = {cap[k][4:0], ser[k]};
                        nbits[k]++;
                    end
                    if (rdy[k] && !dn[k]) rdy_hi[k] = 1'b1;
                end
                if (dn[k]) begin
                    exp_t e;
                    bit   have;
                    chk($sformatf("done_width%0d", k), 32'(done_prev[k]), 32'd0);
                    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (!have || !in_frame[k]) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_done%0d actual=done required=no_done", k);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("frame_nbits%0d", k), 32'(nbits[k]), 32'd6);
                        chk($sformatf("frame_bits%0d", k), 32'(cap[k]), 32'(e.bits));
                        chk($sformatf("ready_low%0d", k), 32'(rdy_hi[k]), 32'd0);
                        if (e.clks != 0)
                            chk($sformatf("frame_clks%0d", k), 32'(cyc[k]), 32'(e.clks));
                    end
                    in_frame[k] = 1'b0;
                end
                if (!busy_prev[k] && bsy[k]) begin
                    in_frame[k] = 1'b1;
                    cap[k]      = {5'b0, ser[k]};
                    nbits[k]    = 1;
                    cyc[k]      = 0;
                    rdy_hi[k]   = 1'b0;
                end
                busy_prev[k] = bsy[k];
                done_prev[k] = dn[k];
            end
        end
    end

    initial begin
        int n;
        clr    = 1'b1;
        load_i = 1'b1;
        ce     = 1'b1;
        data_i = 4'b1111;

        // Reset overrides a simultaneous load and ce.
        @(negedge clk);
        chk_out("rst1", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_out("rst2", 1'b1, 1'b1, 1'b0, 1'b0);
        clr    = 1'b0;
        load_i = 1'b0;
        ce     = 1'b0;
        phase  = 1;
        step();
        step();
        chk_out("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // Basic frames, both bit orders.
        push_exp(6'b010111, 6'b011011, 24);
        send(4'b1011);
        wait_done("f1011");
        push_exp(6'b010001, 6'b000011, 24);
        send(4'b1000);
        wait_done("f1000");

        // load held through a frame with changing data, then back-to-back.
        do step(); while (ce !== 1'b1);
        load_i = 1'b1;
        data_i = 4'b1011;
        push_exp(6'b010111, 6'b011011, 24);
        n = 0;
        do begin
            step();
            data_i = data_i + 4'd5;
            n++;
        end while (dn[0] !== 1'b1 && n < 200);
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL b2b_timeout actual=no_done required=done");
        end
        data_i = 4'b0011;
        push_exp(6'b000111, 6'b011001, 23);
        step();
        load_i = 1'b0;
        data_i = 4'b1111;
        wait_done("b2b");

        // Abort during the second data bit, then a clean frame.
        send(4'b1011);
        for (int i = 0; i < 9; i++) step();
        chk("abort_busy", 32'(bsy[0]), 32'd1);
        clr = 1'b1;
        step();
        chk_out("abort", 1'b1, 1'b1, 1'b0, 1'b0);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_out("post_abort", 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(6'b001101, 6'b001101, 24);
        send(4'b0110);
        wait_done("f0110");

        // ce stalled for 50 clocks in START.
        push_exp(6'b011001, 6'b000111, 0);
        send(4'b1100);
        ce_en = 1'b0;
        for (int i = 0; i < 50; i++) step();
        chk_out("stall", 1'b0, 1'b0, 1'b1, 1'b0);
        ce_en = 1'b1;
        wait_done("stall");

        for (int i = 0; i < 12; i++) step();
        chk("q_empty0", 32'(q0.size()), 32'd0);
        chk("q_empty1", 32'(q1.size()), 32'd0);
        chk_out("final", 1'b1, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
